// File: rtl/ct_lsu_spsram_ctrl_pkg.sv
// Shared types and defaults for the 256x52 single-port SRAM controller.
// Holds the FSM encoding, geometry defaults and the init fill value.
package ct_lsu_spsram_ctrl_pkg;

  localparam int          ADDR_WIDTH_DEF = 8;
  localparam int          DATA_WIDTH_DEF = 52;
  localparam logic [51:0] INIT_VALUE_DEF = 52'b0;
  localparam int          LAST_ADDR      = 2**ADDR_WIDTH_DEF - 1;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int last_addr(input int aw);
    return (2**aw) - 1;
  endfunction

endpackage

// File: rtl/ct_lsu_spsram_ctrl_256x52.sv
// Single-port SRAM controller: init sweep after reset/request, then a
// registered valid/ready read/write port with a 2-cycle read response.
module ct_lsu_spsram_ctrl_256x52
  import ct_lsu_spsram_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = DATA_WIDTH'(INIT_VALUE_DEF)
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic                  init_start,
  output logic                  init_done,
  input  logic                  req_vld,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  req_rdy,
  output logic                  rsp_vld,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(last_addr(ADDR_WIDTH));

  state_e                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  s1_rd;
  logic                  s2_rd;

  // init_start blocks acceptance in the same cycle so re-init always wins.
  assign req_rdy = (state == RUN) & ~init_start;

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state     <= INIT;
      cnt       <= '0;
      init_done <= 1'b0;
      sram_cen  <= 1'b1;
      sram_gwen <= 1'b1;
      sram_wen  <= '1;
      sram_a    <= '0;
      sram_d    <= '0;
      s1_rd     <= 1'b0;
      s2_rd     <= 1'b0;
      rsp_vld   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      // Read pipe: access edge -> SRAM sample edge -> response capture
      s2_rd   <= s1_rd;
      rsp_vld <= s2_rd;
      if (s2_rd) rsp_rdata <= sram_q;

      // Idle by default; address and data hold to avoid needless toggling
      s1_rd     <= 1'b0;
      sram_cen  <= 1'b1;
      sram_gwen <= 1'b1;
      sram_wen  <= '1;

      case (state)
        INIT: begin
          sram_cen  <= 1'b0;
          sram_gwen <= 1'b0;
          sram_wen  <= '0;
          sram_a    <= cnt;
          sram_d    <= INIT_VALUE;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          if (init_start) begin
            state     <= INIT;
            cnt       <= '0;
            init_done <= 1'b0;
          end else if (req_vld) begin
            sram_cen <= 1'b0;
            sram_a   <= req_addr;
            if (req_wr) begin
              sram_gwen <= 1'b0;
              sram_wen  <= ~req_wmask;
              sram_d    <= req_wdata;
            end else begin
              s1_rd <= 1'b1;
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ct_lsu_spsram_ctrl_256x52.sv
// Scoreboard bench for ct_lsu_spsram_ctrl_256x52 with a behavioural SRAM
// macro and an abstract array model of the expected contents.
module tb_ct_lsu_spsram_ctrl_256x52;

  localparam int AW = 8;
  localparam int DW = 52;
  localparam logic [DW-1:0] IV = '0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_start = 1'b0;
  logic          init_done;
  logic          req_vld = 1'b0;
  logic          req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [DW-1:0] req_wmask = '0;
  logic          req_rdy;
  logic          rsp_vld;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] sram_a;
  logic          sram_cen;
  logic          sram_gwen;
  logic [DW-1:0] sram_wen;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;

  ct_lsu_spsram_ctrl_256x52 dut (
    .forever_cpuclk(clk), .cpurst(rst), .init_start(init_start), .init_done(init_done),
    .req_vld(req_vld), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .req_rdy(req_rdy), .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata),
    .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
    .sram_d(sram_d), .sram_q(sram_q)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM macro: active-low pins, Q one cycle after the access edge
  logic [DW-1:0] macro_mem [256];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) begin
        for (int b = 0; b < DW; b++)
          if (!sram_wen[b]) macro_mem[sram_a][b] <= sram_d[b];
      end else begin
        sram_q <= macro_mem[sram_a];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t exp_q[$];

  logic [DW-1:0] ref_mem [256];
  int vecs = 0;
  int miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && rsp_vld) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_vld), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_data", 64'(rsp_rdata), 64'(e.data));
        chk("rsp_latency", 64'(cyc), 64'(e.cyc + 2));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // Drives one request from posedge+1; returns at posedge+1 of the accept edge.
  task automatic do_req(input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] m);
    logic rdy_s;
    logic ok;
    req_vld = 1'b1; req_wr = wr; req_addr = a; req_wdata = d; req_wmask = m;
    @(negedge clk);
    rdy_s = req_rdy;
    @(posedge clk);
    #1;
    if (rdy_s) begin
      if (wr) begin
        ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
        ok = (sram_cen === 1'b0) && (sram_gwen === 1'b0) && (sram_wen === ~m) &&
             (sram_a === a) && (sram_d === d);
        chk("wr_pins", 64'(ok), 64'd1);
      end else begin
        exp_q.push_back('{data: ref_mem[a], cyc: cyc});
        ok = (sram_cen === 1'b0) && (sram_gwen === 1'b1) && (sram_wen === '1) &&
             (sram_a === a);
        chk("rd_pins", 64'(ok), 64'd1);
      end
    end
  endtask

  task automatic idle();
    logic ok;
    req_vld = 1'b0;
    @(posedge clk);
    #1;
    ok = (sram_cen === 1'b1) && (sram_gwen === 1'b1) && (sram_wen === '1);
    chk("idle_pins", 64'(ok), 64'd1);
  endtask

  // Expects a full sweep starting on the next edge; pulses init_start mid-way.
  task automatic check_sweep();
    int bad = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = IV;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== '0 ||
          sram_a !== 8'(i) || sram_d !== IV ||
          init_done !== (i == 255) || req_rdy !== (i == 255))
        bad++;
      init_start = (i == 100);
    end
    init_start = 1'b0;
    chk("sweep_errors", 64'(bad), 64'd0);
    idle();
  endtask

  initial begin
    logic ok;
    repeat (3) @(posedge clk);
    #1;
    ok = (sram_cen === 1'b1) && (sram_gwen === 1'b1) && (sram_wen === '1) &&
         (sram_a === '0) && (sram_d === '0);
    chk("reset_sram_pins", 64'(ok), 64'd1);
    chk("reset_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("reset_init_done", 64'(init_done), 64'd0);
    chk("reset_req_rdy", 64'(req_rdy), 64'd0);
    rst = 1'b0;
    check_sweep();

    // Masked write then read of the same entry
    do_req(1'b1, 8'h5A, 52'hF_FFFF_FFFF_FFFF, 52'h0_0000_FFFF_FFFF);
    chk("wmask_wen", 64'(sram_wen), 64'h000F_FFFF_0000_0000);
    do_req(1'b0, 8'h5A, '0, '0);
    idle(); idle();

    // Back-to-back reads
    do_req(1'b1, 8'h10, 52'hA_BCDE_F012_3456, '1);
    do_req(1'b0, 8'h00, '0, '0);
    do_req(1'b0, 8'hFF, '0, '0);
    do_req(1'b0, 8'h10, '0, '0);
    // Read right after write, and an all-zero-mask write
    do_req(1'b1, 8'h33, 52'h123, '1);
    do_req(1'b0, 8'h33, '0, '0);
    do_req(1'b1, 8'h33, 52'hF_0000_0000_0000, '0);
    do_req(1'b0, 8'h33, '0, '0);
    idle(); idle(); idle();

    // Randomized traffic against the array model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
      end else begin
        logic [AW-1:0] a;
        logic [DW-1:0] d, m;
        a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
        d = {20'($urandom), $urandom};
        m = ($urandom_range(0, 7) == 0) ? '0 : {20'($urandom), $urandom};
        do_req(1'($urandom), a, d, m);
      end
    end
    idle(); idle();

    // Re-init beats a concurrent request; a read already in flight completes
    do_req(1'b0, 8'h10, '0, '0);
    init_start = 1'b1;
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 8'h20;
    @(negedge clk);
    chk("init_start_rdy", 64'(req_rdy), 64'd0);
    @(posedge clk);
    #1;
    init_start = 1'b0;
    req_vld = 1'b0;
    chk("init_start_done_drop", 64'(init_done), 64'd0);
    check_sweep();
    do_req(1'b0, 8'h10, '0, '0);
    idle(); idle();

    // Reset mid-read: response discarded, pins at reset values, fresh sweep
    do_req(1'b1, 8'h44, 52'h5_5555, '1);
    do_req(1'b0, 8'h44, '0, '0);
    req_vld = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    ok = (sram_cen === 1'b1) && (sram_gwen === 1'b1) && (sram_wen === '1) &&
         (sram_a === '0) && (sram_d === '0) && (init_done === 1'b0);
    chk("midop_reset_pins", 64'(ok), 64'd1);
    repeat (4) begin
      @(negedge clk);
      chk("midop_reset_rsp_vld", 64'(rsp_vld), 64'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_sweep();
    do_req(1'b0, 8'h44, '0, '0);
    idle(); idle(); idle();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
